// File: rtl/apb_master.sv
// Single-outstanding APB4 initiator: turns a valid/ready request into
// APB SETUP/ACCESS phases and returns one response pulse per transfer.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic                PREADY,
  input  logic                PSLVERR,
  input  logic [DATA_W-1:0]   PRDATA
);

  localparam int STRB_W = DATA_W / 8;
  // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                req_ready_q, req_ready_d;
  logic                psel_q,      psel_d;
  logic                penable_q,   penable_d;
  logic                pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0]   paddr_q,     paddr_d;
  logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
  logic [STRB_W-1:0]   pstrb_q,     pstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;

  // Next-state and next-output computation for the transfer FSM
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_SETUP;
          req_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = req_write;
          paddr_d     = req_addr;
          pwdata_d    = req_wdata;
          pstrb_d     = req_write ? req_strb : '0;
          cnt_d       = '0;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // A ready slave wins over a timeout landing in the same cycle.
        if (PREADY) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if (TO_EN && (cnt_q == CNT_LIM)) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: per-cycle vector table plus hand-written
// sequences for timeout, back-to-back and mid-transfer reset.
module tb_apb_master;

  logic        PCLK;
  logic        PRESETn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  int errors = 0;
  int checks = 0;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        vld, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic        rdy_in, serr;
    logic [31:0] rdata_in;
    logic        e_rdy, e_sel, e_en, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_strb;
    logic        e_rv, e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt [13];

  localparam logic [31:0] A  = 32'h4000_0008, W  = 32'hA5A5_1234;
  localparam logic [31:0] B  = 32'h4000_0010, BW = 32'h1111_2222;
  localparam logic [31:0] C  = 32'h4000_0020, CW = 32'h3333_4444;
  localparam logic [31:0] Z  = 32'h0000_0000;
  localparam logic [31:0] DB = 32'hDEAD_BEEF, CF = 32'hCAFE_F00D;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_timeout(input int ready_at, input logic [31:0] pdat, output int n_acc);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0030;
    req_wdata = 32'h0; req_strb = 4'hF;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = pdat;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        n_acc++;
        if (n_acc == ready_at) PREADY = 1'b1;
      end else if (n_acc > 0) begin
        break;
      end
      @(posedge PCLK); #1;
    end
    PREADY = 1'b0;
  endtask

  initial begin
    int n, k, nrsp, nzero, nrv, lat;
    int acc [3];
    logic got;

    vt[0]  = '{1'b1,1'b1,A,W,4'hF,1'b0,1'b0,Z,  1'b1,1'b0,1'b0,1'b0,Z,Z,4'h0,1'b0,1'b0,Z};
    vt[1]  = '{1'b0,1'b0,Z,Z,4'h0,1'b0,1'b0,Z,  1'b0,1'b1,1'b0,1'b1,A,W,4'hF,1'b0,1'b0,Z};
    vt[2]  = '{1'b0,1'b0,Z,Z,4'h0,1'b1,1'b0,Z,  1'b0,1'b1,1'b1,1'b1,A,W,4'hF,1'b0,1'b0,Z};
    vt[3]  = '{1'b1,1'b0,B,BW,4'hF,1'b0,1'b0,Z, 1'b1,1'b0,1'b0,1'b1,A,W,4'hF,1'b1,1'b0,Z};
    vt[4]  = '{1'b0,1'b0,Z,Z,4'h0,1'b0,1'b0,Z,  1'b0,1'b1,1'b0,1'b0,B,BW,4'h0,1'b0,1'b0,Z};
    vt[5]  = '{1'b0,1'b0,Z,Z,4'h0,1'b0,1'b1,32'h1234_5678,
               1'b0,1'b1,1'b1,1'b0,B,BW,4'h0,1'b0,1'b0,Z};
    vt[6]  = '{1'b0,1'b0,Z,Z,4'h0,1'b0,1'b0,Z,  1'b0,1'b1,1'b1,1'b0,B,BW,4'h0,1'b0,1'b0,Z};
    vt[7]  = '{1'b0,1'b0,Z,Z,4'h0,1'b1,1'b0,DB, 1'b0,1'b1,1'b1,1'b0,B,BW,4'h0,1'b0,1'b0,Z};
    vt[8]  = '{1'b1,1'b0,C,CW,4'hF,1'b0,1'b0,Z, 1'b1,1'b0,1'b0,1'b0,B,BW,4'h0,1'b1,1'b0,DB};
    vt[9]  = '{1'b0,1'b0,Z,Z,4'h0,1'b0,1'b0,Z,  1'b0,1'b1,1'b0,1'b0,C,CW,4'h0,1'b0,1'b0,DB};
    vt[10] = '{1'b0,1'b0,Z,Z,4'h0,1'b1,1'b1,CF, 1'b0,1'b1,1'b1,1'b0,C,CW,4'h0,1'b0,1'b0,DB};
    vt[11] = '{1'b0,1'b0,Z,Z,4'h0,1'b0,1'b0,Z,  1'b1,1'b0,1'b0,1'b0,C,CW,4'h0,1'b1,1'b1,CF};
    vt[12] = '{1'b0,1'b0,Z,Z,4'h0,1'b0,1'b0,Z,  1'b1,1'b0,1'b0,1'b0,C,CW,4'h0,1'b0,1'b1,CF};

    PRESETn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = Z; req_wdata = Z; req_strb = 4'h0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = Z;
    #12 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Per-cycle table: zero-wait write, 2-wait read, slave error
    for (int i = 0; i < 13; i++) begin
      req_valid = vt[i].vld;  req_write = vt[i].wr;   req_addr = vt[i].addr;
      req_wdata = vt[i].wdata; req_strb = vt[i].strb;
      PREADY = vt[i].rdy_in;  PSLVERR = vt[i].serr;   PRDATA = vt[i].rdata_in;
      @(negedge PCLK);
      chk($sformatf("v%0d.req_ready", i), req_ready, vt[i].e_rdy);
      chk($sformatf("v%0d.psel", i),      PSEL,      vt[i].e_sel);
      chk($sformatf("v%0d.penable", i),   PENABLE,   vt[i].e_en);
      chk($sformatf("v%0d.pwrite", i),    PWRITE,    vt[i].e_wr);
      chk($sformatf("v%0d.paddr", i),     PADDR,     vt[i].e_addr);
      chk($sformatf("v%0d.pwdata", i),    PWDATA,    vt[i].e_wdata);
      chk($sformatf("v%0d.pstrb", i),     PSTRB,     vt[i].e_strb);
      chk($sformatf("v%0d.rsp_valid", i), rsp_valid, vt[i].e_rv);
      chk($sformatf("v%0d.rsp_err", i),   rsp_err,   vt[i].e_err);
      chk($sformatf("v%0d.rsp_rdata", i), rsp_rdata, vt[i].e_rdata);
      @(posedge PCLK); #1;
    end

    // Timeout with PREADY stuck low
    run_timeout(0, 32'hFFFF_FFFF, n);
    chk("to.n_access", n, 5);
    chk("to.psel", PSEL, 1'b0);
    chk("to.penable", PENABLE, 1'b0);
    chk("to.rsp_valid", rsp_valid, 1'b1);
    chk("to.rsp_err", rsp_err, 1'b1);
    chk("to.rsp_rdata", rsp_rdata, 32'h0);
    @(posedge PCLK); #1;

    // PREADY on the 5th ACCESS cycle completes normally
    run_timeout(5, 32'h5A5A_5A5A, n);
    chk("late.n_access", n, 5);
    chk("late.rsp_valid", rsp_valid, 1'b1);
    chk("late.rsp_err", rsp_err, 1'b0);
    chk("late.rsp_rdata", rsp_rdata, 32'h5A5A_5A5A);
    @(posedge PCLK); #1;

    // Back-to-back alternating write/read with req_valid held high
    k = 0; nrsp = 0; nzero = 0;
    for (int j = 0; j < 3; j++) acc[j] = -1;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0000_0077;
    for (int c = 0; c < 12; c++) begin
      if (k < 3) begin
        req_valid = 1'b1; req_write = (k % 2 == 0);
        req_addr = 32'h100 + k * 4; req_wdata = 32'hC0DE_0000 + k; req_strb = 4'hF;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge PCLK);
      if (req_valid && req_ready && k < 3) begin
        acc[k] = c;
        k++;
      end
      if (rsp_valid) begin
        chk($sformatf("b2b.rdata%0d", nrsp), rsp_rdata, (nrsp % 2 == 1) ? 32'h77 : 32'h0);
        nrsp++;
      end
      if (!PSEL && c >= 1 && c <= 8) nzero++;
      @(posedge PCLK); #1;
    end
    chk("b2b.accepts", k, 3);
    chk("b2b.acc0", acc[0], 0);
    chk("b2b.acc1", acc[1], 3);
    chk("b2b.acc2", acc[2], 6);
    chk("b2b.n_rsp", nrsp, 3);
    chk("b2b.psel_gaps", nzero, 2);

    // Reset asserted during ACCESS
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0040; req_strb = 4'hF;
    PREADY = 1'b0;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk("rst.in_access", PSEL && PENABLE, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst.psel_async", PSEL, 1'b0);
    chk("rst.penable_async", PENABLE, 1'b0);
    chk("rst.rsp_valid_async", rsp_valid, 1'b0);
    chk("rst.req_ready_async", req_ready, 1'b1);
    @(posedge PCLK); #1;
    PREADY = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b1;
    nrv = 0;
    repeat (3) begin
      @(negedge PCLK);
      if (rsp_valid) nrv++;
    end
    chk("rst.no_rsp", nrv, 0);
    @(posedge PCLK); #1;

    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4000_0050;
    req_wdata = 32'h0102_0304; req_strb = 4'h3;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hFFFF_0000;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    got = 1'b0; lat = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        got = 1'b1; lat = c;
        break;
      end
      @(posedge PCLK); #1;
    end
    chk("post.rsp_seen", got, 1'b1);
    chk("post.latency", lat, 2);
    chk("post.rsp_err", rsp_err, 1'b0);
    chk("post.rsp_rdata", rsp_rdata, 32'h0);
    chk("post.paddr", PADDR, 32'h4000_0050);
    chk("post.pstrb", PSTRB, 4'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
